// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush, and stall/flush performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam bit HAS_SKID = (SKID_EN != 0);

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              load_skid;
    logic              ready_raw;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = ready_raw & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        load_skid   = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire && HAS_SKID) begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = skid_ctrl;
                        main_data_d = skid_data;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

    generate
        if (HAS_SKID) begin : g_skid
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [DATA_W-1:0] skid_data_q;
            logic              ready_q;

            // ready_q mirrors (state != SKID) one edge early so in_ready has no path from out_ready
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                    ready_q     <= 1'b1;
                end else begin
                    if (load_skid) begin
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                    end
                    ready_q <= (state_d != ST_SKID);
                end
            end

            assign skid_ctrl = skid_ctrl_q;
            assign skid_data = skid_data_q;
            assign ready_raw = ready_q;
        end else begin : g_noskid
            assign skid_ctrl = '0;
            assign skid_data = '0;
            assign ready_raw = ~out_valid | out_ready;
        end
    endgenerate

    assign out_ctrl = main_ctrl_q & {CTRL_W{out_valid}};
    assign out_data = main_data_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush & (state_q != ST_EMPTY)),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid instance, one non-skid instance
// with narrow counters so saturation is reachable.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m;
    logic          iv, ordy, fl;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;

    logic          rdy0, rdy1, ov0, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
    logic [15:0]   sc0, fc0;
    logic [3:0]    sc1, fc1;

    logic          s_rdy, s_ov;
    logic [CW-1:0] s_oc;
    logic [DW-1:0] s_od;
    int unsigned   s_sc, s_fc;

    beat_t         q[$];
    logic [DW-1:0] exp_data;
    int unsigned   exp_stall, exp_flush, n_out;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(fl & ~m), .in_valid(iv & ~m), .in_ready(rdy0),
        .in_ctrl(ic), .in_data(id), .out_valid(ov0), .out_ready(ordy & ~m),
        .out_ctrl(oc0), .out_data(od0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush(fl & m), .in_valid(iv & m), .in_ready(rdy1),
        .in_ctrl(ic), .in_data(id), .out_valid(ov1), .out_ready(ordy & m),
        .out_ctrl(oc1), .out_data(od1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    assign s_rdy = m ? rdy1 : rdy0;
    assign s_ov  = m ? ov1 : ov0;
    assign s_oc  = m ? oc1 : oc0;
    assign s_od  = m ? od1 : od0;
    assign s_sc  = m ? 32'(sc1) : 32'(sc0);
    assign s_fc  = m ? 32'(fc1) : 32'(fc0);

    task automatic model_reset();
        q.delete();
        exp_data  = '0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    // Called at a negedge with inputs already driven; compares, updates the model, returns at the next negedge.
    task automatic step(output bit fin);
        logic          exp_rdy, exp_v;
        logic [CW-1:0] exp_c;
        int unsigned   cap;
        #1;
        cap = m ? 32'd15 : 32'd65535;
        exp_v = (q.size() != 0);
        if (fl) exp_rdy = 1'b0;
        else if (!m) exp_rdy = (q.size() < 2);
        else exp_rdy = !exp_v || ordy;
        exp_c = exp_v ? q[0].ctrl : '0;
        checks++;
        if (s_rdy !== exp_rdy) begin errors++; $display("FAIL in_ready t=%0t act=%b exp=%b", $time, s_rdy, exp_rdy); end
        checks++;
        if (s_ov !== exp_v) begin errors++; $display("FAIL out_valid t=%0t act=%b exp=%b", $time, s_ov, exp_v); end
        checks++;
        if (s_oc !== exp_c) begin errors++; $display("FAIL out_ctrl t=%0t act=%h exp=%h", $time, s_oc, exp_c); end
        checks++;
        if (s_od !== exp_data) begin errors++; $display("FAIL out_data t=%0t act=%h exp=%h", $time, s_od, exp_data); end
        checks++;
        if (s_sc !== exp_stall) begin errors++; $display("FAIL stall_cnt t=%0t act=%0d exp=%0d", $time, s_sc, exp_stall); end
        checks++;
        if (s_fc !== exp_flush) begin errors++; $display("FAIL flush_cnt t=%0t act=%0d exp=%0d", $time, s_fc, exp_flush); end
        fin = iv && exp_rdy;
        if (exp_v && !ordy && exp_stall < cap) exp_stall++;
        if (fl && exp_v && exp_flush < cap) exp_flush++;
        if (exp_v && ordy) begin
            void'(q.pop_front());
            n_out++;
        end
        if (fl) q.delete();
        else if (fin) q.push_back(beat_t'{ic, id});
        if (q.size() != 0) exp_data = q[0].data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        m = 1'b0; rst = 1'b1; iv = 1'b0; ordy = 1'b0; fl = 1'b0; ic = '0; id = '0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({ov0, ov1} !== 2'b00) begin errors++; $display("FAIL reset_valid act=%b%b exp=00", ov0, ov1); end
        checks++;
        if ({oc0, oc1, od0, od1} !== '0) begin errors++; $display("FAIL reset_payload act=%h%h%h%h exp=0", oc0, oc1, od0, od1); end
        checks++;
        if ({sc0, fc0, sc1, fc1} !== '0) begin errors++; $display("FAIL reset_counters act=%h%h%h%h exp=0", sc0, fc0, sc1, fc1); end
        rst = 1'b0;
        #1;
        checks++;
        if ({rdy0, rdy1} !== 2'b11) begin errors++; $display("FAIL reset_in_ready act=%b%b exp=11", rdy0, rdy1); end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        bit f;
        ordy = 1'b1;
        n_out = 0;
        for (int i = 1; i <= 8; i++) begin
            iv = 1'b1; ic = 8'hFF; id = DW'(i);
            if (i > 1) begin
                #1;
                checks++;
                if (s_ov !== 1'b1 || s_od !== DW'(i - 1)) begin
                    errors++; $display("FAIL stream_out i=%0d act=%b/%h exp=1/%h", i, s_ov, s_od, DW'(i - 1));
                end
            end
            step(f);
            checks++;
            if (!f) begin errors++; $display("FAIL stream_accept i=%0d act=0 exp=1", i); end
        end
        iv = 1'b0;
        step(f);
        step(f);
        checks++;
        if (n_out !== 8) begin errors++; $display("FAIL stream_count act=%0d exp=8", n_out); end
        checks++;
        if (s_sc !== 0) begin errors++; $display("FAIL stream_stall act=%0d exp=0", s_sc); end
    endtask

    task automatic test_backpressure();
        bit f;
        int idx = 0;
        int c = 0;
        n_out = 0;
        while ((idx < 10 || q.size() != 0) && c < 60) begin
            iv = (idx < 10); ic = CW'(idx + 1); id = DW'(32'h11 + idx);
            ordy = !(c >= 4 && c < 7);
            if (c == 5) begin
                #1;
                checks++;
                if (s_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_drop act=%b exp=0", s_rdy); end
            end
            step(f);
            if (f) idx++;
            c++;
        end
        iv = 1'b0; ordy = 1'b1;
        checks++;
        if (c >= 60) begin errors++; $display("FAIL bp_timeout act=%0d beats exp=10", idx); end
        checks++;
        if (n_out !== 10) begin errors++; $display("FAIL bp_count act=%0d exp=10", n_out); end
        #1;
        checks++;
        if (s_sc !== 3) begin errors++; $display("FAIL bp_stall act=%0d exp=3", s_sc); end
        @(negedge clk);
    endtask

    task automatic test_flush_skid();
        bit f;
        ordy = 1'b0;
        iv = 1'b1; ic = 8'hA5; id = 32'hAAAA_0001;
        step(f);
        iv = 1'b1; ic = 8'h5B; id = 32'hBBBB_0002;
        step(f);
        fl = 1'b1; iv = 1'b1; ic = 8'h3C; id = 32'hCCCC_0003;
        #1;
        checks++;
        if (s_rdy !== 1'b0) begin errors++; $display("FAIL flush_ready act=%b exp=0", s_rdy); end
        step(f);
        fl = 1'b0;
        #1;
        checks++;
        if (s_ov !== 1'b0 || s_oc !== 8'h00) begin errors++; $display("FAIL flush_out act=%b/%h exp=0/00", s_ov, s_oc); end
        checks++;
        if (s_od !== 32'hAAAA_0001) begin errors++; $display("FAIL flush_data act=%h exp=aaaa0001", s_od); end
        checks++;
        if (s_fc !== 1) begin errors++; $display("FAIL flush_cnt_skid act=%0d exp=1", s_fc); end
        step(f);
        checks++;
        if (!f) begin errors++; $display("FAIL flush_next_accept act=0 exp=1"); end
        iv = 1'b0; ordy = 1'b1;
        step(f);
        step(f);
    endtask

    task automatic test_flush_empty();
        bit f;
        iv = 1'b0; ordy = 1'b1; fl = 1'b1;
        step(f);
        fl = 1'b0;
        #1;
        checks++;
        if (s_fc !== 1) begin errors++; $display("FAIL flush_empty_cnt act=%0d exp=1", s_fc); end
        checks++;
        if (s_rdy !== 1'b1) begin errors++; $display("FAIL flush_empty_ready act=%b exp=1", s_rdy); end
        step(f);
    endtask

    task automatic test_async_reset();
        bit f;
        ordy = 1'b0;
        iv = 1'b1; ic = 8'h77; id = 32'h7777_0001;
        step(f);
        id = 32'h7777_0002;
        step(f);
        iv = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ov0, oc0} !== '0) begin errors++; $display("FAIL areset_out act=%b/%h exp=0/00", ov0, oc0); end
        checks++;
        if (od0 !== '0) begin errors++; $display("FAIL areset_data act=%h exp=0", od0); end
        checks++;
        if ({sc0, fc0} !== '0) begin errors++; $display("FAIL areset_cnt act=%0d/%0d exp=0/0", sc0, fc0); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL areset_ready act=%b exp=1", rdy0); end
        @(negedge clk);
    endtask

    task automatic test_noskid_random();
        bit f = 1'b1;
        m = 1'b1;
        model_reset();
        n_out = 0;
        iv = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!iv || f) begin
                iv = ($urandom_range(0, 1) == 1);
                ic = CW'($urandom);
                id = DW'($urandom);
            end
            ordy = ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (s_rdy !== (~s_ov | ordy)) begin
                errors++; $display("FAIL noskid_ready c=%0d act=%b exp=%b", c, s_rdy, ~s_ov | ordy);
            end
            step(f);
        end
        iv = 1'b0; ordy = 1'b1;
        step(f);
        step(f);
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL noskid_drain act=%0d exp=0", q.size()); end
        checks++;
        if (s_sc !== 15) begin errors++; $display("FAIL noskid_stall_sat act=%0d exp=15", s_sc); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_skid();
        test_flush_empty();
        test_async_reset();
        test_noskid_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
